m_uart_rx_fifo: RTL and testbench

Serial console receiver: the input direction of the UART console, complementary to the existing `UartTx` output path. It samples an asynchronous 8N1 serial line, reassembles bytes, and buffers them in a small show-ahead FIFO. The CPU-side bus glue pops bytes through a one-cycle read strobe. It sits in `m_topsim` beside `UartTx`, sharing `CLK` and the baud setting.

---
 rtl/m_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_m_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_uart_rx_fifo.sv
// Console UART receiver: 2-flop synchronizer, 8N1 deframer and show-ahead byte FIFO popped by a read strobe.
// A byte is visible 3+H+9W cycles after i_rxd falls; the line cannot be stalled, so a full FIFO drops the byte and raises o_overrun.

module fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_rdy,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  output logic [AW:0]   cnt
);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [1<<AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_nxt;
  logic [AW:0]   cnt_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic [DW-1:0] head_nxt;

  assign empty  = (cnt_q == '0);
  assign wr_rdy = (cnt_q != FULL_CNT) || rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && !empty;
  assign rd_nxt = pop ? rd_ptr + ONE : rd_ptr;

  // Bypass the array when the incoming byte lands in the slot that becomes the head.
  assign head_nxt = (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? wr_dat : mem[rd_nxt[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      rd_dat <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      rd_ptr <= rd_nxt;
      if (push && !pop) begin
        cnt_q <= cnt_q + ONE;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - ONE;
      end
      if (pop || (push && empty)) begin
        rd_dat <= head_nxt;
      end
    end
  end

  assign rd_vld = !empty;
  assign cnt    = cnt_q;
endmodule

module m_uart_rx_fifo #(
  parameter int SERIAL_WCNT     = 20,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_rxd,
  input  logic                     i_rd,
  input  logic                     i_clr_err,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  output logic [FIFO_DEPTH_LOG2:0] o_count,
  output logic                     o_frame_err,
  output logic                     o_overrun
);
  localparam int              CW      = $clog2(SERIAL_WCNT);
  localparam logic [CW-1:0]   W_LAST  = CW'(SERIAL_WCNT - 1);
  localparam logic [CW-1:0]   H_LAST  = CW'(SERIAL_WCNT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic          rxs_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          cnt_clr;
  logic          bit_smp;
  logic          rx_push;
  logic          ferr_set;
  logic          ovr_set;
  logic          fifo_wr_rdy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_rxd};
      rxs_d  <= rxs;
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start needs a high-to-low edge, so a low stop bit cannot retrigger until the line is seen high.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    bit_smp  = 1'b0;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs && rxs_d) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (cnt_q == H_LAST) begin
          cnt_clr = 1'b1;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == W_LAST) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == W_LAST) begin
          cnt_clr  = 1'b1;
          state_d  = IDLE;
          rx_push  = rxs;
          ferr_set = !rxs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + CNT_ONE;
      if (state_q == IDLE) begin
        idx_q <= '0;
      end else if (bit_smp) begin
        idx_q   <= idx_q + 3'd1;
        shift_q <= {rxs, shift_q[7:1]};
      end
    end
  end

  fifo #(
    .DW (8),
    .AW (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .wr_vld (rx_push),
    .wr_dat (shift_q),
    .wr_rdy (fifo_wr_rdy),
    .rd_rdy (i_rd),
    .rd_vld (o_valid),
    .rd_dat (o_data),
    .cnt    (o_count)
  );

  assign ovr_set = rx_push && !fifo_wr_rdy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
      if (ovr_set) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m_uart_rx_fifo.sv
// Bench for m_uart_rx_fifo: frames driven bit-by-bit, checked every cycle against a byte-queue model of the receiver.

module tb_m_uart_rx_fifo;
  localparam int W         = 16;
  localparam int H         = W / 2;
  localparam int L         = 4;
  localparam int DEPTH     = 1 << L;
  localparam int PUSH_EDGE = H + 9 * W + 3;

  logic       CLK;
  logic       RST;
  logic       i_rxd;
  logic       i_rd;
  logic       i_clr_err;
  logic [7:0] o_data;
  logic       o_valid;
  logic [L:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  int         n_vec;
  int         n_err;
  int         first_vld_k;
  logic [7:0] q[$];
  bit         m_ferr;
  bit         m_ovr;

  m_uart_rx_fifo #(
    .SERIAL_WCNT     (W),
    .FIFO_DEPTH_LOG2 (L)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_rxd       (i_rxd),
    .i_rd        (i_rd),
    .i_clr_err   (i_clr_err),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_count     (o_count),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the coming edge, then compare at the next negedge.
  task automatic tick(input logic rxd, input logic rd, input logic clr,
                      input bit ev_push, input bit ev_ferr, input logic [7:0] pb);
    bit ovr_set;
    ovr_set   = 1'b0;
    i_rxd     = rxd;
    i_rd      = rd;
    i_clr_err = clr;
    if (ev_push) begin
      if (q.size() == DEPTH && !rd) begin
        ovr_set = 1'b1;
      end else begin
        if (rd && q.size() > 0) void'(q.pop_front());
        q.push_back(pb);
      end
    end else if (rd && q.size() > 0) begin
      void'(q.pop_front());
    end
    m_ferr = ev_ferr ? 1'b1 : (clr ? 1'b0 : m_ferr);
    m_ovr  = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    @(negedge CLK);
    check_val("count", 32'(o_count), 32'(q.size()));
    check_val("valid", 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) check_val("data", 32'(o_data), 32'(q[0]));
    check_val("frame_err", 32'(o_frame_err), 32'(m_ferr));
    check_val("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    i_rxd     = 1'b1;
    i_rd      = 1'b0;
    i_clr_err = 1'b0;
    #1;
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_val("rst_count", 32'(o_count), 0);
    check_val("rst_valid", 32'(o_valid), 0);
    check_val("rst_data", 32'(o_data), 0);
    check_val("rst_frame_err", 32'(o_frame_err), 0);
    check_val("rst_overrun", 32'(o_overrun), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic idle(input int n, input int pop_pct, input int clr_pct);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, $urandom_range(99) < pop_pct, $urandom_range(99) < clr_pct, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int pop_pct,
                            input int force_k, input int clr_pct, input int rst_k);
    logic rxd;
    logic rd;
    logic clr;
    int   bi;
    for (int k = 0; k < 10 * W; k++) begin
      if (k == rst_k) begin
        do_reset();
        return;
      end
      bi = k / W;
      if (bi == 0) rxd = 1'b0;
      else if (bi <= 8) rxd = b[bi-1];
      else rxd = stop_hi;
      rd  = (k == force_k) || ($urandom_range(99) < pop_pct);
      clr = $urandom_range(99) < clr_pct;
      tick(rxd, rd, clr, (k + 1 == PUSH_EDGE) && stop_hi, (k + 1 == PUSH_EDGE) && !stop_hi, b);
      if (first_vld_k < 0 && o_valid) first_vld_k = k + 1;
    end
  endtask

  task automatic drain(output logic [7:0] last);
    last = 8'h00;
    for (int n = 0; n < DEPTH + 2 && q.size() > 0; n++) begin
      last = o_data;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    check_val("drain_empty", 32'(o_count), 0);
  endtask

  initial begin
    logic [7:0] last;
    int         pct;
    n_vec       = 0;
    n_err       = 0;
    first_vld_k = -1;
    m_ferr      = 1'b0;
    m_ovr       = 1'b0;
    RST         = 1'b0;
    i_rxd       = 1'b1;
    i_rd        = 1'b0;
    i_clr_err   = 1'b0;
    @(negedge CLK);
    do_reset();
    idle(5, 0, 0);

    // 0x41: exact arrival latency, then a single pop empties the FIFO
    first_vld_k = -1;
    send_frame(8'h41, 1'b1, 0, -1, 0, -1);
    check_val("vld_latency", 32'(first_vld_k), 32'(PUSH_EDGE));
    check_val("t1_data", 32'(o_data), 32'h41);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("t1_pop_valid", 32'(o_valid), 0);
    idle(4, 0, 0);

    // three-cycle glitch must be rejected, next frame still received
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(30, 0, 0);
    send_frame(8'h5A, 1'b1, 0, -1, 0, -1);
    idle(2, 0, 0);
    drain(last);
    check_val("t2_byte", 32'(last), 32'h5A);

    // low stop bit: dropped byte and sticky frame error, cleared by strobe
    send_frame(8'h55, 1'b0, 0, -1, 0, -1);
    idle(4, 0, 0);
    check_val("t3_ferr", 32'(o_frame_err), 1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(8'hA3, 1'b1, 0, -1, 0, -1);
    idle(2, 0, 0);
    drain(last);
    check_val("t3_byte", 32'(last), 32'hA3);

    // 17 bytes into 16 slots: overrun, then in-order wrap-around drain
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 0, -1, 0, -1);
      idle(1, 0, 0);
    end
    check_val("t4_count", 32'(o_count), 16);
    check_val("t4_ovr", 32'(o_overrun), 1);
    drain(last);
    check_val("t4_last", 32'(last), 32'h0F);

    // full FIFO with a pop in the exact push cycle
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom), 1'b1, 0, -1, 0, -1);
      idle(1, 0, 0);
    end
    send_frame(8'h77, 1'b1, 0, PUSH_EDGE - 1, 0, -1);
    idle(2, 0, 0);
    check_val("t5_count", 32'(o_count), 16);
    check_val("t5_ovr", 32'(o_overrun), 0);
    drain(last);
    check_val("t5_last", 32'(last), 32'h77);

    // reset during data bit 4 discards everything
    send_frame(8'($urandom), 1'b1, 0, -1, 0, -1);
    idle(2, 0, 0);
    send_frame(8'hA0, 1'b1, 0, -1, 0, 5 * W + H);
    idle(5, 0, 0);
    send_frame(8'hC3, 1'b1, 0, -1, 0, -1);
    idle(2, 0, 0);
    check_val("t6_ferr", 32'(o_frame_err), 0);
    drain(last);
    check_val("t6_byte", 32'(last), 32'hC3);

    // randomized traffic: random bytes, pops, clears and occasional bad stop bits
    for (int f = 0; f < 30; f++) begin
      pct = $urandom_range(60);
      send_frame(8'($urandom), $urandom_range(9) != 0, pct, -1, 2, -1);
      idle($urandom_range(1, 4), pct, 2);
    end
    idle(2, 0, 0);
    drain(last);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
